ex_mem_skid_stage: RTL and testbench
====================================

EX_MEM_SKID_STAGE -- requirements
Module: ex_mem_skid_stage

Interface
REQ-001 Parameter DATA_W, default 32, width of ALU result and store data.
REQ-002 Parameter RD_W, default 5, destination register index width.
REQ-003 Parameter CTRL_W, default 4, control bundle width; bits [0..3] are reg_write, mem_read, mem_write, mem_to_reg.
REQ-004 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_flush  input  1  synchronous kill of all held entries.
REQ-007 i_in_valid  input  1  upstream (EX) payload valid.
REQ-008 o_in_ready  output  1  stage can accept this cycle.
REQ-009 i_alu_result, i_write_data  input  DATA_W each  upstream payload.
REQ-010 i_rd  input  RD_W  upstream destination index.
REQ-011 i_ctrl  input  CTRL_W  upstream control bundle.
REQ-012 o_out_valid  output  1  downstream (MEM) payload valid.
REQ-013 i_out_ready  input  1  downstream accepts this cycle.
REQ-014 o_alu_result, o_write_data, o_rd, o_ctrl  output  widths as inputs  downstream payload.
REQ-015 o_occupancy  output  2  number of held entries (0..2).

Function
REQ-016 Transfer in occurs when i_in_valid && o_in_ready && !i_flush; transfer out when o_out_valid && i_out_ready.
REQ-017 Storage: main slot (drives outputs) plus one skid slot; states EMPTY (0), ONE (main), FULL (main+skid).
REQ-018 o_in_ready SHALL be a registered signal equal to (state != FULL); no combinational path from i_out_ready.
REQ-019 EMPTY: transfer in -> ONE, main loaded.
REQ-020 ONE: in only -> FULL if !i_out_ready (skid loaded), else main reloaded, stay ONE; out only -> EMPTY; in and out -> main reloaded, stay ONE.
REQ-021 FULL: out -> skid moves to main, ONE; no input accepted in FULL.
REQ-022 Latency: accepted payload visible on outputs next cycle when stage was EMPTY or draining; throughput one per cycle with i_out_ready held high.
REQ-023 While o_out_valid && !i_out_ready, all o_* payload SHALL hold stable.
REQ-024 Order preserved: skid entry always exits after main entry.
REQ-025 i_flush (priority over all) SHALL go to EMPTY next cycle, discarding main, skid and any same-cycle input; o_in_ready = 1 next cycle.
REQ-026 o_ctrl SHALL be forced to zero whenever o_out_valid = 0 (bubble never writes register file or memory); other payload outputs keep last value.
REQ-027 o_occupancy SHALL equal 0/1/2 for EMPTY/ONE/FULL.
REQ-028 i_rd = 0 with ctrl reg_write=1 SHALL pass unchanged; suppression is the register file's job.

Reset
REQ-029 On i_reset_n low, immediately: state EMPTY, o_out_valid 0, o_in_ready 0 while asserted, o_occupancy 0, all payload and o_ctrl 0.
REQ-030 o_in_ready SHALL rise on the first i_clk edge after reset release; reset mid-transfer discards all entries.

Structure
REQ-031 Shared package ex_mem_pkg holds control bit index constants (CTRL_REG_WRITE=0, CTRL_MEM_READ=1, CTRL_MEM_WRITE=2, CTRL_MEM_TO_REG=3), default widths and the state encoding.
REQ-032 One sub-module pipe_slot (parametrised payload register with load enable, async active-low clear), instantiated twice.

Verification
REQ-033 Streaming: i_out_ready=1, push alu_result 0x10,0x20,0x30 back-to-back -> outputs 0x10,0x20,0x30 on consecutive cycles, occupancy never exceeds 1.
REQ-034 Backpressure: i_out_ready=0, push 0xA then 0xB -> occupancy 2, o_in_ready 0, outputs hold 0xA; raise i_out_ready -> 0xA then 0xB, o_in_ready 1 after one transfer out.
REQ-035 Flush in FULL with i_in_valid=1, payload 0xC -> next cycle o_out_valid 0, o_ctrl 0, occupancy 0; 0xC never appears.
REQ-036 Bubble: ctrl=4'b0101 accepted and drained, then no input -> o_out_valid 0 and o_ctrl 4'b0000.
REQ-037 Async reset asserted mid-cycle while FULL -> outputs zero before next i_clk edge; o_in_ready 1 one edge after release.
REQ-038 Random valid/ready stress, DATA_W=64, RD_W=6 -> scoreboard sees every accepted item exactly once, in order.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// EX/MEM skid stage shared definitions.
// Control bit indices, default widths and FSM state encoding.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int RD_W_DEF   = 5;
  localparam int CTRL_W_DEF = 4;

  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_READ   = 1;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_MEM_TO_REG = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/ex_mem_skid_stage_pipe_slot.sv
// Payload register with load enable.
// Cleared asynchronously by the stage reset.
module pipe_slot #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] q_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      q_q <= '0;
    end else if (i_load) begin
      q_q <= i_d;
    end
  end

  assign o_q = q_q;

endmodule

// File: rtl/ex_mem_skid_stage.sv
// EX->MEM pipeline register with one-entry skid buffer.
// Ready is registered so no comb path from downstream ready.
module ex_mem_skid_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_flush,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_alu_result,
  input  logic [DATA_W-1:0] i_write_data,
  input  logic [RD_W-1:0]   i_rd,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_alu_result,
  output logic [DATA_W-1:0] o_write_data,
  output logic [RD_W-1:0]   o_rd,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic [1:0]        o_occupancy
);

  localparam int PW = CTRL_W + RD_W + 2 * DATA_W;

  state_e        state_q, state_d;
  logic          in_ready_q;
  logic          in_fire, out_fire;
  logic          main_ld, skid_ld, main_from_skid;
  logic [PW-1:0] in_pl, main_d, main_q, skid_q;

  assign in_pl    = {i_ctrl, i_rd, i_write_data, i_alu_result};
  assign in_fire  = i_in_valid && in_ready_q && !i_flush;
  assign out_fire = o_out_valid && i_out_ready;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    if (i_flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_ld = 1'b1;
          end
        end
        ST_ONE: begin
          if (in_fire && !out_fire) begin
            state_d = ST_FULL;
            skid_ld = 1'b1;
          end else if (in_fire) begin
            main_ld = 1'b1;
          end else if (out_fire) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire) begin
            state_d        = ST_ONE;
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign main_d = main_from_skid ? skid_q : in_pl;

  pipe_slot #(.W(PW)) u_main (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (main_ld),
    .i_d       (main_d),
    .o_q       (main_q)
  );

  pipe_slot #(.W(PW)) u_skid (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_load    (skid_ld),
    .i_d       (in_pl),
    .o_q       (skid_q)
  );

  assign o_in_ready   = in_ready_q;
  assign o_out_valid  = (state_q != ST_EMPTY);
  assign o_occupancy  = state_q;
  assign o_alu_result = main_q[DATA_W-1:0];
  assign o_write_data = main_q[2*DATA_W-1:DATA_W];
  assign o_rd         = main_q[2*DATA_W+RD_W-1:2*DATA_W];
  // A bubble must never write the register file or memory.
  assign o_ctrl = o_out_valid ? main_q[PW-1:PW-CTRL_W] : '0;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench for ex_mem_skid_stage.
// Queue reference model, directed scenarios, then random stress.
module tb_ex_mem_skid_stage;

  localparam int DW = 64;
  localparam int RW = 6;
  localparam int CW = 4;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [RW-1:0] rd;
    logic [DW-1:0] wd;
    logic [DW-1:0] alu;
  } item_t;

  logic          i_clk = 1'b0;
  logic          i_reset_n;
  logic          i_flush;
  logic          i_in_valid;
  logic          o_in_ready;
  logic [DW-1:0] i_alu_result;
  logic [DW-1:0] i_write_data;
  logic [RW-1:0] i_rd;
  logic [CW-1:0] i_ctrl;
  logic          o_out_valid;
  logic          i_out_ready;
  logic [DW-1:0] o_alu_result;
  logic [DW-1:0] o_write_data;
  logic [RW-1:0] o_rd;
  logic [CW-1:0] o_ctrl;
  logic [1:0]    o_occupancy;

  int nvec = 0;
  int nmis = 0;

  item_t mq[$];
  item_t last_m;
  logic  ready_m;

  always #5 i_clk = ~i_clk;

  ex_mem_skid_stage #(.DATA_W(DW), .RD_W(RW), .CTRL_W(CW)) dut (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_flush      (i_flush),
    .i_in_valid   (i_in_valid),
    .o_in_ready   (o_in_ready),
    .i_alu_result (i_alu_result),
    .i_write_data (i_write_data),
    .i_rd         (i_rd),
    .i_ctrl       (i_ctrl),
    .o_out_valid  (o_out_valid),
    .i_out_ready  (i_out_ready),
    .o_alu_result (o_alu_result),
    .o_write_data (o_write_data),
    .o_rd         (o_rd),
    .o_ctrl       (o_ctrl),
    .o_occupancy  (o_occupancy)
  );

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    item_t cur;
    logic  v;
    v   = (mq.size() > 0);
    cur = v ? mq[0] : last_m;
    chk("valid", DW'(o_out_valid), DW'(v));
    chk("ready", DW'(o_in_ready), DW'(ready_m));
    chk("occ", DW'(o_occupancy), DW'(mq.size()));
    chk("ctrl", DW'(o_ctrl), v ? DW'(cur.ctrl) : '0);
    chk("alu", o_alu_result, cur.alu);
    chk("wd", o_write_data, cur.wd);
    chk("rd", DW'(o_rd), DW'(cur.rd));
  endtask

  task automatic model_reset();
    mq.delete();
    last_m  = '0;
    ready_m = 1'b0;
  endtask

  task automatic cycle();
    logic  inf, outf;
    item_t it;
    inf  = i_in_valid && ready_m && !i_flush && i_reset_n;
    outf = (mq.size() > 0) && i_out_ready;
    it   = {i_ctrl, i_rd, i_write_data, i_alu_result};
    @(posedge i_clk);
    if (i_reset_n) begin
      if (i_flush) begin
        mq.delete();
      end else begin
        if (outf) void'(mq.pop_front());
        if (inf) mq.push_back(it);
      end
      ready_m = (mq.size() != 2);
      if (mq.size() > 0) last_m = mq[0];
    end
    #1;
    check_all();
  endtask

  task automatic push(input logic v, input logic [DW-1:0] a,
                      input logic [CW-1:0] c, input logic r);
    i_in_valid   = v;
    i_alu_result = a;
    i_write_data = ~a;
    i_rd         = a[RW-1:0];
    i_ctrl       = c;
    i_out_ready  = r;
    cycle();
  endtask

  initial begin
    i_reset_n    = 1'b0;
    i_flush      = 1'b0;
    i_in_valid   = 1'b0;
    i_alu_result = '0;
    i_write_data = '0;
    i_rd         = '0;
    i_ctrl       = '0;
    i_out_ready  = 1'b0;
    model_reset();
    #3;
    check_all();
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    push(1'b0, 64'h0, 4'h0, 1'b1);

    // streaming
    push(1'b1, 64'h10, 4'b0001, 1'b1);
    chk("occ_le1", DW'(o_occupancy <= 2'd1), 64'd1);
    push(1'b1, 64'h20, 4'b1011, 1'b1);
    chk("occ_le1", DW'(o_occupancy <= 2'd1), 64'd1);
    push(1'b1, 64'h30, 4'b0101, 1'b1);
    chk("occ_le1", DW'(o_occupancy <= 2'd1), 64'd1);
    push(1'b1, 64'h40, 4'b0001, 1'b1);
    push(1'b0, 64'h0, 4'h0, 1'b1);
    push(1'b0, 64'h0, 4'h0, 1'b1);

    // backpressure
    push(1'b1, 64'hA, 4'b0011, 1'b0);
    push(1'b1, 64'hB, 4'b0101, 1'b0);
    push(1'b1, 64'hD, 4'b0001, 1'b0);
    push(1'b0, 64'h0, 4'h0, 1'b0);
    push(1'b0, 64'h0, 4'h0, 1'b1);
    push(1'b0, 64'h0, 4'h0, 1'b1);

    // flush while full, with a same-cycle input
    push(1'b1, 64'h1, 4'b0001, 1'b0);
    push(1'b1, 64'h2, 4'b0010, 1'b0);
    i_flush = 1'b1;
    push(1'b1, 64'hC, 4'b0111, 1'b0);
    i_flush = 1'b0;
    push(1'b0, 64'h0, 4'h0, 1'b1);

    // bubble after drain
    push(1'b1, 64'h55, 4'b0101, 1'b1);
    push(1'b0, 64'h0, 4'h0, 1'b1);
    chk("bubble_ctrl", DW'(o_ctrl), 64'd0);

    // async reset while full
    push(1'b1, 64'h77, 4'b0001, 1'b0);
    push(1'b1, 64'h88, 4'b0100, 1'b0);
    #2;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    check_all();
    push(1'b1, 64'h99, 4'b0001, 1'b1);
    i_reset_n = 1'b1;
    push(1'b0, 64'h0, 4'h0, 1'b1);

    // random stress
    for (int n = 0; n < 3000; n++) begin
      i_flush      = ($urandom_range(0, 39) == 0);
      i_in_valid   = ($urandom_range(0, 9) < 6);
      i_out_ready  = ($urandom_range(0, 9) < 5);
      i_alu_result = {$urandom, $urandom};
      i_write_data = {$urandom, $urandom};
      i_rd         = RW'($urandom);
      i_ctrl       = CW'($urandom);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
